// File: rtl/exc_flush_ctrl.sv
// Precise exception/interrupt flush controller for the M stage: snapshots the victim
// instruction, waits out a busy mult/div unit, then issues the TAKE or RET flush.
module exc_flush_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        hwint,
    input  logic [5:0]        im,
    input  logic              ie,
    input  logic              exl,
    input  logic [4:0]        exc_m,
    input  logic [DATA_W-1:0] pc_m,
    input  logic              bd_m,
    input  logic              eret_m,
    input  logic              md_busy,
    output logic              stall_all,
    output logic              intexc,
    output logic              epc_we,
    output logic [DATA_W-1:0] epc_out,
    output logic [4:0]        cause_exc,
    output logic              cause_bd,
    output logic              exl_set,
    output logic              exl_clr,
    output logic [1:0]        npc_sel
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MD_WAIT = 2'd1;
    localparam logic [1:0] S_TAKE    = 2'd2;
    localparam logic [1:0] S_RET     = 2'd3;

    localparam logic [1:0] NPC_NORMAL  = 2'b00;
    localparam logic [1:0] NPC_HANDLER = 2'b01;
    localparam logic [1:0] NPC_EPC     = 2'b10;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              int_req;
    logic              exc_req;
    logic              req;

    logic [4:0]        snap_code;
    logic [DATA_W-1:0] snap_epc;
    logic              snap_bd;
    logic              snap_epc_we;

    // A delay-slot victim restarts at its branch so the branch is re-executed.
    function automatic logic [DATA_W-1:0] victim_epc(input logic [DATA_W-1:0] pc,
                                                     input logic              bd);
        return bd ? (pc - DATA_W'(4)) : pc;
    endfunction

    assign int_req = ie & ~exl & (|(hwint & im));
    assign exc_req = (exc_m != 5'd0);
    assign req     = int_req | exc_req;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req)
                    state_nxt = md_busy ? S_MD_WAIT : S_TAKE;
                else if (eret_m)
                    state_nxt = S_RET;
            end
            S_MD_WAIT: begin
                if (!md_busy)
                    state_nxt = S_TAKE;
            end
            S_TAKE:  state_nxt = S_IDLE;
            S_RET:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Snapshot is taken only on the accepting IDLE cycle and stays frozen until the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_code   <= 5'd0;
            snap_epc    <= '0;
            snap_bd     <= 1'b0;
            snap_epc_we <= 1'b0;
        end else if ((state == S_IDLE) && req) begin
            snap_code   <= int_req ? 5'd0 : exc_m;
            snap_epc    <= victim_epc(pc_m, bd_m);
            snap_bd     <= bd_m;
            snap_epc_we <= ~exl;
        end
    end

    // Outputs are held at zero while reset is asserted so no flush escapes a reset cycle.
    always_comb begin
        stall_all = 1'b0;
        intexc    = 1'b0;
        epc_we    = 1'b0;
        epc_out   = '0;
        cause_exc = 5'd0;
        cause_bd  = 1'b0;
        exl_set   = 1'b0;
        exl_clr   = 1'b0;
        npc_sel   = NPC_NORMAL;
        if (!reset) begin
            case (state)
                S_IDLE:    stall_all = req;
                S_MD_WAIT: stall_all = 1'b1;
                S_TAKE: begin
                    intexc    = 1'b1;
                    epc_we    = snap_epc_we;
                    epc_out   = snap_epc;
                    cause_exc = snap_code;
                    cause_bd  = snap_bd;
                    exl_set   = 1'b1;
                    npc_sel   = NPC_HANDLER;
                end
                S_RET: begin
                    intexc  = 1'b1;
                    exl_clr = 1'b1;
                    npc_sel = NPC_EPC;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_flush_ctrl.sv
// Bench for exc_flush_ctrl: directed vectors with literal expectations, plus a
// rule-level model compared against every output on every cycle.
module tb_exc_flush_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  hwint;
    logic [5:0]  im;
    logic        ie;
    logic        exl;
    logic [4:0]  exc_m;
    logic [31:0] pc_m;
    logic        bd_m;
    logic        eret_m;
    logic        md_busy;
    logic        stall_all;
    logic        intexc;
    logic        epc_we;
    logic [31:0] epc_out;
    logic [4:0]  cause_exc;
    logic        cause_bd;
    logic        exl_set;
    logic        exl_clr;
    logic [1:0]  npc_sel;

    exc_flush_ctrl #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .hwint(hwint), .im(im), .ie(ie), .exl(exl),
        .exc_m(exc_m), .pc_m(pc_m), .bd_m(bd_m), .eret_m(eret_m), .md_busy(md_busy),
        .stall_all(stall_all), .intexc(intexc), .epc_we(epc_we), .epc_out(epc_out),
        .cause_exc(cause_exc), .cause_bd(cause_bd), .exl_set(exl_set),
        .exl_clr(exl_clr), .npc_sel(npc_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: pending flush events and the recorded victim.
    bit          waiting_md;
    bit          flush_take;
    bit          flush_ret;
    logic [4:0]  v_code;
    logic [31:0] v_epc;
    bit          v_bd;
    bit          v_save_epc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit interrupt_pending();
        return ie && !exl && ((hwint & im) != 6'd0);
    endfunction

    // Compare every output with what the rules demand for the current cycle.
    task automatic sample();
        bit          quiet;
        bit          request;
        bit          e_stall;
        logic [1:0]  e_npc;
        @(negedge clk);
        quiet   = !(waiting_md || flush_take || flush_ret);
        request = interrupt_pending() || (exc_m != 5'd0);
        e_stall = !reset && ((quiet && request) || waiting_md);
        e_npc   = reset ? 2'd0 : (flush_take ? 2'd1 : (flush_ret ? 2'd2 : 2'd0));
        chk("stall_all", 32'(stall_all), 32'(e_stall));
        chk("intexc",    32'(intexc),    32'(!reset && (flush_take || flush_ret)));
        chk("epc_we",    32'(epc_we),    32'(!reset && flush_take && v_save_epc));
        chk("epc_out",   epc_out,        (!reset && flush_take) ? v_epc : 32'd0);
        chk("cause_exc", 32'(cause_exc), (!reset && flush_take) ? 32'(v_code) : 32'd0);
        chk("cause_bd",  32'(cause_bd),  32'(!reset && flush_take && v_bd));
        chk("exl_set",   32'(exl_set),   32'(!reset && flush_take));
        chk("exl_clr",   32'(exl_clr),   32'(!reset && flush_ret));
        chk("npc_sel",   32'(npc_sel),   32'(e_npc));
    endtask

    // Advance the model across the clock edge, then let the caller change inputs.
    task automatic advance();
        bit quiet;
        bit request;
        @(posedge clk);
        quiet   = !(waiting_md || flush_take || flush_ret);
        request = interrupt_pending() || (exc_m != 5'd0);
        if (reset) begin
            waiting_md = 0; flush_take = 0; flush_ret = 0;
            v_code = 0; v_epc = 0; v_bd = 0; v_save_epc = 0;
        end else if (quiet) begin
            if (request) begin
                v_code     = interrupt_pending() ? 5'd0 : exc_m;
                v_epc      = bd_m ? pc_m - 32'd4 : pc_m;
                v_bd       = bd_m;
                v_save_epc = !exl;
                if (md_busy) waiting_md = 1; else flush_take = 1;
            end else if (eret_m) begin
                flush_ret = 1;
            end
        end else if (waiting_md) begin
            if (!md_busy) begin
                waiting_md = 0;
                flush_take = 1;
            end
        end else begin
            flush_take = 0;
            flush_ret  = 0;
        end
        #1;
    endtask

    task automatic clear_inputs();
        hwint = 0; im = 0; ie = 0; exl = 0; exc_m = 0;
        pc_m = 0; bd_m = 0; eret_m = 0; md_busy = 0;
    endtask

    initial begin
        int stall_cnt;
        waiting_md = 0; flush_take = 0; flush_ret = 0;
        v_code = 0; v_epc = 0; v_bd = 0; v_save_epc = 0;
        reset = 1;
        clear_inputs();

        sample(); advance();
        sample(); advance();
        reset = 0;
        sample();
        chk("reset stall_all", 32'(stall_all), 32'd0);
        chk("reset npc_sel", 32'(npc_sel), 32'd0);
        advance();

        // Overflow exception in M
        exc_m = 5'd12; pc_m = 32'h0000_3010;
        sample();
        chk("ov stall", 32'(stall_all), 32'd1);
        advance();
        exc_m = 0;
        sample();
        chk("ov intexc", 32'(intexc), 32'd1);
        chk("ov epc_we", 32'(epc_we), 32'd1);
        chk("ov epc_out", epc_out, 32'h0000_3010);
        chk("ov cause", 32'(cause_exc), 32'd12);
        chk("ov npc_sel", 32'(npc_sel), 32'd1);
        chk("ov stall in take", 32'(stall_all), 32'd0);
        advance();

        // Interrupt on a delay-slot instruction
        hwint = 6'b000100; im = 6'b000100; ie = 1; pc_m = 32'h0000_3024; bd_m = 1;
        sample();
        chk("ds stall", 32'(stall_all), 32'd1);
        advance();
        hwint = 0; bd_m = 0;
        sample();
        chk("ds epc_out", epc_out, 32'h0000_3020);
        chk("ds cause_bd", 32'(cause_bd), 32'd1);
        chk("ds cause_exc", 32'(cause_exc), 32'd0);
        advance();

        // Interrupt while mult/div is busy for five cycles
        hwint = 6'b000001; im = 6'b000001; ie = 1; pc_m = 32'h0000_5000; md_busy = 1;
        stall_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            md_busy = (i < 5);
            sample();
            stall_cnt += int'(stall_all);
            advance();
            hwint = 0; pc_m = 32'h0000_6000; eret_m = 1;
        end
        eret_m = 0;
        sample();
        chk("md stall cycles", 32'(stall_cnt), 32'd6);
        chk("md intexc", 32'(intexc), 32'd1);
        chk("md epc_out", epc_out, 32'h0000_5000);
        advance();

        // Masked interrupts
        hwint = 6'b001000; im = 6'b001000; ie = 0;
        sample(); chk("ie0 stall", 32'(stall_all), 32'd0); advance();
        sample(); chk("ie0 intexc", 32'(intexc), 32'd0); advance();
        ie = 1; exl = 1;
        sample(); chk("exl1 stall", 32'(stall_all), 32'd0); advance();
        sample(); chk("exl1 intexc", 32'(intexc), 32'd0); advance();
        hwint = 0; exc_m = 5'd10;
        sample(); advance();
        exc_m = 0;
        sample();
        chk("exl1 exc intexc", 32'(intexc), 32'd1);
        chk("exl1 exc epc_we", 32'(epc_we), 32'd0);
        chk("exl1 exc cause", 32'(cause_exc), 32'd10);
        advance();

        // ERET alone, then ERET colliding with an exception
        eret_m = 1;
        sample(); chk("eret stall", 32'(stall_all), 32'd0); advance();
        eret_m = 0;
        sample();
        chk("eret intexc", 32'(intexc), 32'd1);
        chk("eret exl_clr", 32'(exl_clr), 32'd1);
        chk("eret npc_sel", 32'(npc_sel), 32'd2);
        advance();
        eret_m = 1; exc_m = 5'd4; exl = 0; pc_m = 32'h0000_7000;
        sample(); chk("eret+exc stall", 32'(stall_all), 32'd1); advance();
        eret_m = 0; exc_m = 0;
        sample();
        chk("eret+exc npc_sel", 32'(npc_sel), 32'd1);
        chk("eret+exc exl_clr", 32'(exl_clr), 32'd0);
        chk("eret+exc cause", 32'(cause_exc), 32'd4);
        advance();
        sample(); chk("after take idle", 32'(intexc), 32'd0); advance();

        // Reset in the middle of a mult/div wait
        hwint = 6'b100000; im = 6'b100000; ie = 1; md_busy = 1;
        sample(); advance();
        hwint = 0;
        sample(); chk("mdw stall", 32'(stall_all), 32'd1); advance();
        reset = 1;
        sample(); advance();
        reset = 0; md_busy = 0;
        sample();
        chk("rst stall", 32'(stall_all), 32'd0);
        chk("rst intexc", 32'(intexc), 32'd0);
        advance();
        sample(); chk("rst no take", 32'(intexc), 32'd0); advance();

        // Pseudo-random traffic checked only by the model
        for (int i = 0; i < 300; i++) begin
            reset   = ($urandom_range(0, 39) == 0);
            hwint   = 6'($urandom);
            im      = 6'($urandom);
            ie      = ($urandom_range(0, 3) == 0);
            exl     = ($urandom_range(0, 1) == 0);
            exc_m   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            pc_m    = {$urandom} & 32'hFFFF_FFFC;
            bd_m    = ($urandom_range(0, 1) == 0);
            eret_m  = ($urandom_range(0, 5) == 0);
            md_busy = ($urandom_range(0, 2) == 0);
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
